// File: rtl/wu_fetch_if.sv
// Fetch-to-memory read port: registered stall from wu_memory, address and read strobe from wu_fetch.
interface wu_fetch_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic [ADDR_W-1:0] wuf__wum__addr;
  logic              wuf__wum__read;
  logic              wum__wuf__stall;

  modport master (
    output wuf__wum__addr,
    output wuf__wum__read,
    input  wum__wuf__stall
  );

  modport slave (
    input  wuf__wum__addr,
    input  wuf__wum__read,
    output wum__wuf__stall
  );

endinterface

// File: rtl/wu_fetch.sv
// Work-unit instruction fetch: WU program counter, read issue into wu_memory,
// jump/halt redirects with in-flight tracking so stale reads are flushed and halt drains.
module wu_fetch #(
  parameter int unsigned WUF_MEM_LATENCY              = 3,
  parameter int unsigned WUF_CNT_WIDTH                = 32,
  parameter int unsigned MGR_WU_ADDRESS_WIDTH         = 10,
  parameter int unsigned MGR_INSTRUCTION_MEMORY_DEPTH = 512,
  parameter int unsigned MGR_MGR_ID_WIDTH             = 6
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic [MGR_MGR_ID_WIDTH-1:0]     sys__mgr__mgrId,
  input  logic                            sys__wuf__start,
  input  logic [MGR_WU_ADDRESS_WIDTH-1:0] sys__wuf__start_addr,
  wu_fetch_if.master                      wum,
  input  logic                            wud__wuf__jump_valid,
  input  logic [MGR_WU_ADDRESS_WIDTH-1:0] wud__wuf__jump_addr,
  input  logic                            wud__wuf__halt,
  output logic                            wuf__wud__flush,
  output logic                            wuf__sys__busy,
  output logic                            wuf__sys__complete,
  output logic [WUF_CNT_WIDTH-1:0]        wuf__sys__fetch_count
);

  localparam int unsigned AW  = MGR_WU_ADDRESS_WIDTH;
  localparam int unsigned CW  = WUF_CNT_WIDTH;
  localparam int unsigned LAT = WUF_MEM_LATENCY;

  localparam logic [AW-1:0] PC_LAST = AW'(MGR_INSTRUCTION_MEMORY_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]     state, state_nx;
  logic [AW-1:0]  pc, pc_nx, pc_inc;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [LAT-1:0] infl, infl_nx;
  logic           read_c;
  logic           infl_empty;

  // Stall is already registered by memory, so the read strobe reacts to it in the same cycle.
  always_comb begin
    read_c     = (state == RUN) & ~wum.wum__wuf__stall & ~wud__wuf__jump_valid & ~wud__wuf__halt;
    infl_nx    = LAT'({infl, read_c});
    infl_empty = (infl == '0);
    pc_inc     = (pc == PC_LAST) ? '0 : pc + AW'(1);
  end

  assign wum.wuf__wum__read  = read_c;
  assign wum.wuf__wum__addr  = pc;
  assign wuf__sys__fetch_count = cnt;

  // Next-state and datapath update; halt outranks jump in every state that honours them.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (sys__wuf__start) begin
          pc_nx    = sys__wuf__start_addr;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (wud__wuf__halt) begin
          state_nx = DRAIN;
        end else if (wud__wuf__jump_valid) begin
          pc_nx    = wud__wuf__jump_addr;
          state_nx = FLUSH;
        end else if (read_c) begin
          pc_nx = pc_inc;
          if (cnt != CNT_MAX) cnt_nx = cnt + CW'(1);
        end
      end
      FLUSH: begin
        if (wud__wuf__halt) begin
          state_nx = DRAIN;
        end else if (wud__wuf__jump_valid) begin
          pc_nx = wud__wuf__jump_addr;
        end else if (infl_empty) begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        if (infl_empty) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Flush is raised only in cycles where a stale instruction actually lands at decode.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state              <= IDLE;
      pc                 <= '0;
      cnt                <= '0;
      infl               <= '0;
      wuf__wud__flush    <= 1'b0;
      wuf__sys__busy     <= 1'b0;
      wuf__sys__complete <= 1'b0;
    end else begin
      state              <= state_nx;
      pc                 <= pc_nx;
      cnt                <= cnt_nx;
      infl               <= infl_nx;
      wuf__wud__flush    <= ((state_nx == FLUSH) | (state_nx == DRAIN)) & infl_nx[LAT-1];
      wuf__sys__busy     <= (state_nx != IDLE);
      wuf__sys__complete <= (state_nx == DONE);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset_poweron && sys__wuf__start && (state != IDLE))
      $display("%m: WARNING mgr %0d start ignored, fetch already busy", sys__mgr__mgrId);
  end
`endif

endmodule

// File: tb/tb_wu_fetch.sv
// Directed bench for wu_fetch: per-cycle reference model plus hand-computed spot checks.
module tb_wu_fetch;

  localparam int unsigned LAT   = 3;
  localparam int unsigned CW    = 5;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned IDW   = 6;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic [IDW-1:0] mgr_id;
  logic          start, jump, halt;
  logic [AW-1:0] start_addr, jump_addr;
  logic          flush, busy, complete;
  logic [CW-1:0] fcount;

  always #5 clk = ~clk;

  wu_fetch_if #(.ADDR_W(AW)) mem_if ();

  wu_fetch #(
    .WUF_MEM_LATENCY              (LAT),
    .WUF_CNT_WIDTH                (CW),
    .MGR_WU_ADDRESS_WIDTH         (AW),
    .MGR_INSTRUCTION_MEMORY_DEPTH (DEPTH),
    .MGR_MGR_ID_WIDTH             (IDW)
  ) dut (
    .clk                   (clk),
    .reset_poweron         (reset_poweron),
    .sys__mgr__mgrId       (mgr_id),
    .sys__wuf__start       (start),
    .sys__wuf__start_addr  (start_addr),
    .wum                   (mem_if),
    .wud__wuf__jump_valid  (jump),
    .wud__wuf__jump_addr   (jump_addr),
    .wud__wuf__halt        (halt),
    .wuf__wud__flush       (flush),
    .wuf__sys__busy        (busy),
    .wuf__sys__complete    (complete),
    .wuf__sys__fetch_count (fcount)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: fetcher described as modes plus a list of cycles in which reads were issued.
  bit m_busy, m_fetch, m_redir, m_halt, m_done;
  int m_pc, m_cnt;
  int issued[$];

  always @(negedge clk) begin : model_blk
    bit e_read, arriving, pending;
    e_read   = m_fetch && !mem_if.wum__wuf__stall && !jump && !halt;
    arriving = 1'b0;
    pending  = 1'b0;
    foreach (issued[i]) begin
      if (issued[i] == cyc - int'(LAT)) arriving = 1'b1;
      if (issued[i] >= cyc - int'(LAT)) pending = 1'b1;
    end

    check("read",     32'(mem_if.wuf__wum__read), 32'(e_read));
    check("addr",     32'(mem_if.wuf__wum__addr), 32'(m_pc));
    check("flush",    32'(flush),    32'((m_redir || m_halt) && arriving));
    check("busy",     32'(busy),     32'(m_busy));
    check("complete", 32'(complete), 32'(m_done));
    check("count",    32'(fcount),   32'(m_cnt));

    if (reset_poweron) begin
      {m_busy, m_fetch, m_redir, m_halt, m_done} = '0;
      m_pc  = 0;
      m_cnt = 0;
      issued.delete();
    end else begin
      if (e_read) issued.push_back(cyc);
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_halt) begin
        if (!pending) begin
          m_halt = 1'b0;
          m_done = 1'b1;
        end
      end else if (m_redir) begin
        if (halt) begin
          m_redir = 1'b0;
          m_halt  = 1'b1;
        end else if (jump) begin
          m_pc = int'(jump_addr);
        end else if (!pending) begin
          m_redir = 1'b0;
          m_fetch = 1'b1;
        end
      end else if (m_fetch) begin
        if (halt) begin
          m_fetch = 1'b0;
          m_halt  = 1'b1;
        end else if (jump) begin
          m_pc    = int'(jump_addr);
          m_fetch = 1'b0;
          m_redir = 1'b1;
        end else if (e_read) begin
          m_pc = (m_pc + 1) % int'(DEPTH);
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end else if (start) begin
        m_busy  = 1'b1;
        m_fetch = 1'b1;
        m_pc    = int'(start_addr);
        m_cnt   = 0;
      end
    end
    while (issued.size() > 0 && issued[0] < cyc - int'(LAT) + 1) void'(issued.pop_front());
    cyc++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_poweron = 1'b1;
    mem_if.wum__wuf__stall = 1'b1;
    mgr_id     = 6'd5;
    start      = 1'b0;
    jump       = 1'b0;
    halt       = 1'b0;
    start_addr = '0;
    jump_addr  = '0;

    // reset values
    step(2); #2;
    check("rst_read", 32'(mem_if.wuf__wum__read), 32'd0);
    check("rst_addr", 32'(mem_if.wuf__wum__addr), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_complete", 32'(complete), 32'd0);
    check("rst_count", 32'(fcount), 32'd0);
    step(2);
    reset_poweron = 1'b0;

    // jump/halt in IDLE are ignored
    step; mem_if.wum__wuf__stall = 1'b0; jump = 1'b1; jump_addr = 10'h055; halt = 1'b1;
    step; jump = 1'b0; halt = 1'b0; #2;
    check("idle_busy", 32'(busy), 32'd0);

    // start at 0x10, free running
    start = 1'b1; start_addr = 10'h010;
    step; start = 1'b0; #2;
    check("run_addr0", 32'(mem_if.wuf__wum__addr), 32'h10);
    check("run_read0", 32'(mem_if.wuf__wum__read), 32'd1);
    check("run_busy",  32'(busy), 32'd1);
    step; #2;
    check("run_addr1", 32'(mem_if.wuf__wum__addr), 32'h11);
    check("run_cnt1",  32'(fcount), 32'd1);
    step; #2;
    check("run_addr2", 32'(mem_if.wuf__wum__addr), 32'h12);

    // stall for 5 cycles
    step; mem_if.wum__wuf__stall = 1'b1; #2;
    check("stall_read", 32'(mem_if.wuf__wum__read), 32'd0);
    step(4); #2;
    check("stall_addr", 32'(mem_if.wuf__wum__addr), 32'h13);
    step; mem_if.wum__wuf__stall = 1'b0; #2;
    check("resume_addr", 32'(mem_if.wuf__wum__addr), 32'h13);
    check("resume_cnt",  32'(fcount), 32'd3);

    // start while running is ignored
    step; start = 1'b1; start_addr = 10'h099;
    step; start = 1'b0; #2;
    check("start_run_addr", 32'(mem_if.wuf__wum__addr), 32'h15);

    // jump to 0x40 with three reads in flight
    step(2); jump = 1'b1; jump_addr = 10'h040; #2;
    check("jump_read", 32'(mem_if.wuf__wum__read), 32'd0);
    step; jump = 1'b0; #2;
    check("flush_t1", 32'(flush), 32'd1);
    check("flush_t1_read", 32'(mem_if.wuf__wum__read), 32'd0);
    step; #2;
    check("flush_t2", 32'(flush), 32'd1);
    step; #2;
    check("flush_t3", 32'(flush), 32'd0);
    check("flush_t3_read", 32'(mem_if.wuf__wum__read), 32'd0);
    step; #2;
    check("post_jump_read", 32'(mem_if.wuf__wum__read), 32'd1);
    check("post_jump_addr", 32'(mem_if.wuf__wum__addr), 32'h40);

    // halt and jump together with three reads in flight: halt wins
    step(4); halt = 1'b1; jump = 1'b1; jump_addr = 10'h077; #2;
    check("halt_addr", 32'(mem_if.wuf__wum__addr), 32'h44);
    step; halt = 1'b0; jump = 1'b0; #2;
    check("drain_flush1", 32'(flush), 32'd1);
    check("drain_addr", 32'(mem_if.wuf__wum__addr), 32'h44);
    step; #2;
    check("drain_flush2", 32'(flush), 32'd1);
    step; #2;
    check("drain_flush3", 32'(flush), 32'd0);
    check("drain_cpl3", 32'(complete), 32'd0);
    step; #2;
    check("complete", 32'(complete), 32'd1);
    step; #2;
    check("after_cpl", 32'(complete), 32'd0);
    check("after_busy", 32'(busy), 32'd0);

    // second start at DEPTH-2: wrap, then count saturation
    step(2); start = 1'b1; start_addr = 10'h1FE;
    step; start = 1'b0; #2;
    check("wrap_a0", 32'(mem_if.wuf__wum__addr), 32'h1FE);
    check("wrap_cnt0", 32'(fcount), 32'd0);
    step; #2;
    check("wrap_a1", 32'(mem_if.wuf__wum__addr), 32'h1FF);
    step; #2;
    check("wrap_a2", 32'(mem_if.wuf__wum__addr), 32'h000);
    step; #2;
    check("wrap_a3", 32'(mem_if.wuf__wum__addr), 32'h001);
    step(30); #2;
    check("sat_cnt", 32'(fcount), 32'd31);
    check("sat_addr", 32'(mem_if.wuf__wum__addr), 32'h01F);

    // jump, re-jump in FLUSH, halt in FLUSH
    jump = 1'b1; jump_addr = 10'h100;
    step; jump_addr = 10'h120;
    step; jump = 1'b0; #2;
    check("rejump_addr", 32'(mem_if.wuf__wum__addr), 32'h120);
    check("rejump_flush", 32'(flush), 32'd1);
    step; halt = 1'b1; #2;
    check("fl_halt_read", 32'(mem_if.wuf__wum__read), 32'd0);
    step; halt = 1'b0; #2;
    check("fl_drain_busy", 32'(busy), 32'd1);
    step; #2;
    check("fl_complete", 32'(complete), 32'd1);
    step(2);

    // reset asserted in FLUSH
    start = 1'b1; start_addr = 10'h030;
    step; start = 1'b0;
    step(3); jump = 1'b1; jump_addr = 10'h060;
    step; jump = 1'b0; #2;
    check("pre_rst_flush", 32'(flush), 32'd1);
    reset_poweron = 1'b1; mem_if.wum__wuf__stall = 1'b1;
    step; reset_poweron = 1'b0; #2;
    check("rstfl_read", 32'(mem_if.wuf__wum__read), 32'd0);
    check("rstfl_addr", 32'(mem_if.wuf__wum__addr), 32'd0);
    check("rstfl_flush", 32'(flush), 32'd0);
    check("rstfl_busy", 32'(busy), 32'd0);
    check("rstfl_complete", 32'(complete), 32'd0);
    check("rstfl_count", 32'(fcount), 32'd0);
    step; mem_if.wum__wuf__stall = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
